bfloat_mac_seq: RTL

BFLOAT_MAC_SEQ -- requirements
Module: bfloat_mac_seq

---
 rtl/bfloat_mac_seq_if.sv | 35 +++
 rtl/bfloat_mac_seq.sv | 119 +++++++++++
 2 files changed

// File: rtl/bfloat_mac_seq_if.sv
`timescale 1ns/1ps
// Purpose : bundles the sequencer's operand, MAC-stage and result signals.
// Latency : none (wiring only).
// Backpress: in_valid/in_ready on operands, res_valid/res_ready on results.
// Ports   : slave = sequencer view, master = producer/MAC/consumer view.
interface bfloat_mac_seq_if #(
  parameter int LW = 5
);
  logic          start;
  logic [LW-1:0] len;
  logic          cntl;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a;
  logic [15:0]   in_b;
  logic [15:0]   mac_a;
  logic [15:0]   mac_b;
  logic          mac_cntl;
  logic          mac_clr;
  logic [15:0]   mac_out;
  logic          res_valid;
  logic          res_ready;
  logic [15:0]   res_data;
  logic          busy;

  modport slave (
    input  start, len, cntl, in_valid, in_a, in_b, mac_out, res_ready,
    output in_ready, mac_a, mac_b, mac_cntl, mac_clr, res_valid, res_data, busy
  );

  modport master (
    output start, len, cntl, in_valid, in_a, in_b, mac_out, res_ready,
    input  in_ready, mac_a, mac_b, mac_cntl, mac_clr, res_valid, res_data, busy
  );
endinterface

// File: rtl/bfloat_mac_seq.sv
`timescale 1ns/1ps
// Purpose : sequences one bfloat16 dot product through an external MAC stage.
// Latency : result valid MAC_LAT+1 cycles after the last accepted operand pair.
// Backpress: in_ready only while pairs are owed; result held until res_ready.
// Ports   : clk, rst (async, active high); bus = bfloat_mac_seq_if.slave
//           (start/len/cntl request, in_* operands, mac_* MAC stage, res_* result, busy).
module bfloat_mac_seq #(
  parameter int MAX_LEN = 16,
  parameter int MAC_LAT = 3,
  parameter int LW      = $clog2(MAX_LEN) + 1
) (
  input logic             clk,
  input logic             rst,
  bfloat_mac_seq_if.slave bus
);
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [LW-1:0] MAX_LEN_W = LW'(MAX_LEN);
  localparam logic [DW-1:0] DRN_LAST  = DW'(MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] drn_q, drn_d;
  logic          cntl_q, cntl_d;
  logic [15:0]   a_q, a_d;
  logic [15:0]   b_q, b_d;
  logic [15:0]   res_q, res_d;
  logic          in_ready;
  logic          xfer;

  assign in_ready = (state_q == FEED) && (cnt_q < len_q);
  assign xfer     = in_ready && bus.in_valid;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    cntl_d  = cntl_q;
    res_d   = res_q;
    // Non-transfer cycles present a zero product so the accumulator holds.
    a_d     = xfer ? bus.in_a : 16'h0000;
    b_d     = xfer ? bus.in_b : 16'h0000;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cntl_d = bus.cntl;
          cnt_d  = '0;
          if (bus.len == '0) begin
            // Empty vector: the dot product is zero, the MAC is never touched.
            res_d   = 16'h0000;
            state_d = DONE;
          end else begin
            len_d   = (bus.len > MAX_LEN_W) ? MAX_LEN_W : bus.len;
            state_d = CLEAR;
          end
        end
      end
      CLEAR: state_d = FEED;
      FEED: begin
        if (xfer) begin
          cnt_d = cnt_q + LW'(1);
          if (cnt_q + LW'(1) == len_q) begin
            drn_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The last pair sits on mac_a/mac_b during the first DRAIN cycle;
        // mac_out is sampled on the MAC_LAT-th DRAIN cycle.
        if (drn_q == DRN_LAST) begin
          res_d   = bus.mac_out;
          state_d = DONE;
        end else begin
          drn_d = drn_q + DW'(1);
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      cntl_q  <= 1'b0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      res_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      cntl_q  <= cntl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mac_a     = a_q;
  assign bus.mac_b     = b_q;
  assign bus.mac_cntl  = cntl_q;
  assign bus.mac_clr   = (state_q == CLEAR);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
